mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access and writeback stage of the rv32i pipeline.
- Consumes the memory-stage pipeline outputs (regwriteM, resultsrcM, memwriteM, aluresultM, Rd2M, RdM).
- Runs a req/gnt/rvalid handshake to data memory for loads and stores, stalling upstream while a transaction is outstanding.
- Registers the writeback stage and drives the register-file write port (we, addr_3, wd_3) through regwriteW, RdW and resultW.

Parameters:
DPW  32  datapath width (rv32i_pkg)
ADW  5  register address width

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
validM  input  1  M-stage holds a valid instruction
regwriteM  input  1  instruction writes the register file
resultsrcM  input  1  1 = load (result from memory)
memwriteM  input  1  1 = store
aluresultM  input  DPW  ALU result / memory address
Rd2M  input  DPW  store data
RdM  input  ADW  destination register
stallM  output  1  combinational; upstream holds M inputs and earlier stages
dmem_req  output  1  memory request
dmem_we  output  1  1 = write
dmem_addr  output  DPW  word address (aluresultM)
dmem_wdata  output  DPW  Rd2M
dmem_gnt  input  1  request accepted
dmem_rvalid  input  1  response valid (load data or store ack)
dmem_rdata  input  DPW  load data
regwriteW  output  1  register-file write enable
RdW  output  ADW  register-file write address
resultW  output  DPW  register-file write data
misalign_err  output  1  one-cycle pulse: misaligned memory op dropped

Behaviour:
- Reset: rst asynchronous, active-high. FSM goes to IDLE. regwriteW, RdW, resultW and misalign_err all 0. dmem_req is 0 while rst is high.
- Memory op definition: validM & (resultsrcM | memwriteM).
- resultsrcM & memwriteM together is treated as a store; no writeback.
- Non-memory op (validM=1, neither flag set):
  - W register loads at the next edge: regwriteW = regwriteM, RdW = RdM, resultW = aluresultM.
  - Latency 1 cycle, no stall.
- validM=0: bubble at the next edge (regwriteW=0). RdW and resultW hold their values.
- x0 guard: regwriteW is forced to 0 whenever RdM == 0.
- FSM states: IDLE, REQ, RESP.
  - IDLE, aligned memory op:
    - dmem_req=1 combinationally, with dmem_we = memwriteM, dmem_addr = aluresultM, dmem_wdata = Rd2M.
    - gnt in the same cycle: go to RESP. Otherwise go to REQ.
  - REQ: dmem_req held at 1 with stable fields until gnt; on gnt go to RESP.
  - RESP: dmem_req=0; wait for rvalid.
    - On rvalid, go to IDLE.
    - Load: W loads regwriteW = regwriteM, RdW = RdM, resultW = dmem_rdata.
    - Store: W loads a bubble (regwriteW=0).
- rvalid is never accepted in the same cycle as gnt. Earliest accepted rvalid is the cycle after gnt.
- stallM = aligned memory op present & ~(state==RESP & dmem_rvalid).
  - stallM deasserts in the rvalid cycle, so upstream advances at that edge.
  - Best case (gnt immediate, rvalid next cycle): 2-cycle occupancy, stallM high for 1 cycle.
- W register loads a bubble on every stalled edge, so no duplicate writeback occurs.
- Upstream holds all M inputs stable while stallM=1.
- Misaligned memory op (aluresultM[1:0] != 0):
  - No request is issued and there is no stall.
  - misalign_err pulses 1 cycle (registered, at the next edge) and W gets a bubble.
- dmem_rvalid in IDLE or REQ is ignored.
- rst mid-transaction: FSM returns to IDLE and the request is abandoned. A late rvalid after reset is ignored.

Optional Feature:
- Macro: MEM_WB_PERF_EN.
- When defined: extra output stall_cnt (32 bits).
  - Reset to 0.
  - Increments on every cycle with stallM=1.
  - Saturates at 32'hFFFF_FFFF.
- When undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. ALU op: validM=1, regwriteM=1, RdM=5, aluresultM=0x1234 -> next edge regwriteW=1, RdW=5, resultW=0x1234, stallM=0 throughout.
2. Load, addr 0x40, gnt same cycle, rvalid next cycle with rdata=0xDEADBEEF, RdM=7 -> stallM=1 for 1 cycle, regwriteW=1, RdW=7, resultW=0xDEADBEEF after 2 cycles.
3. Store, addr 0x80, Rd2M=0xA5A5A5A5, gnt delayed 3 cycles, rvalid 2 cycles later:
   - dmem_req held 4 cycles with stable addr and wdata.
   - stallM high 5 cycles.
   - regwriteW=0 throughout.
4. Load to x0, rdata=0xFFFFFFFF -> regwriteW stays 0.
5. Misaligned load at addr 0x41 -> dmem_req never asserted, stallM=0, misalign_err=1 for one cycle, regwriteW=0.
6. rst asserted while in RESP, then rvalid arrives after rst release -> FSM in IDLE, regwriteW=0, response ignored; with MEM_WB_PERF_EN, stall_cnt reads 0 after reset.

Source files
------------

// File: rtl/mem_wb_stage.sv
// rv32i memory-access + writeback stage: req/gnt/rvalid data-memory handshake and W register.
// Optional MEM_WB_PERF_EN adds a saturating stall-cycle counter on output stall_cnt.
module mem_wb_stage #(
   parameter int DPW = 32,
   parameter int ADW = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           validM,
   input  logic           regwriteM,
   input  logic           resultsrcM,
   input  logic           memwriteM,
   input  logic [DPW-1:0] aluresultM,
   input  logic [DPW-1:0] Rd2M,
   input  logic [ADW-1:0] RdM,
   output logic           stallM,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic [DPW-1:0] dmem_addr,
   output logic [DPW-1:0] dmem_wdata,
   input  logic           dmem_gnt,
   input  logic           dmem_rvalid,
   input  logic [DPW-1:0] dmem_rdata,
   output logic           regwriteW,
   output logic [ADW-1:0] RdW,
   output logic [DPW-1:0] resultW,
`ifdef MEM_WB_PERF_EN
   output logic [31:0]    stall_cnt,
`endif
   output logic           misalign_err
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t r_state;

   logic w_memop, w_misal, w_amem, w_done, w_wr_ok;

   assign w_memop = validM & (resultsrcM | memwriteM);
   assign w_misal = aluresultM[1:0] != 2'b00;
   assign w_amem  = w_memop & ~w_misal;
   assign w_done  = (r_state == RESP) & dmem_rvalid;
   assign w_wr_ok = regwriteM & (RdM != '0);

   // Request fields come straight from M; upstream holds them while stalled.
   assign dmem_req   = ~rst & (((r_state == IDLE) & w_amem) | (r_state == REQ));
   assign dmem_we    = memwriteM;
   assign dmem_addr  = aluresultM;
   assign dmem_wdata = Rd2M;
   assign stallM     = w_amem & ~w_done;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_amem) r_state <= dmem_gnt ? RESP : REQ;
            REQ:     if (dmem_gnt) r_state <= RESP;
            RESP:    if (dmem_rvalid) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Stalled edges, bubbles, dropped misaligned ops and stores all write a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regwriteW    <= 1'b0;
         RdW          <= '0;
         resultW      <= '0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= w_memop & w_misal;
         if (!validM || stallM || (w_memop && w_misal) || (w_done && memwriteM)) begin
            regwriteW <= 1'b0;
         end else begin
            regwriteW <= w_wr_ok;
            RdW       <= RdM;
            resultW   <= w_done ? dmem_rdata : aluresultM;
         end
      end
   end

`ifdef MEM_WB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stall_cnt <= '0;
      else if (stallM && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: transaction-level model compared every cycle plus literal pins.
module tb_mem_wb_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        validM, regwriteM, resultsrcM, memwriteM;
   logic [31:0] aluresultM, Rd2M;
   logic [4:0]  RdM;
   logic        stallM, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_gnt, dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        regwriteW;
   logic [4:0]  RdW;
   logic [31:0] resultW;
   logic        misalign_err;
`ifdef MEM_WB_PERF_EN
   logic [31:0] stall_cnt;
`endif

   int n_total = 0, n_pass = 0;

   mem_wb_stage dut (
      .clk(clk), .rst(rst), .validM(validM), .regwriteM(regwriteM),
      .resultsrcM(resultsrcM), .memwriteM(memwriteM), .aluresultM(aluresultM),
      .Rd2M(Rd2M), .RdM(RdM), .stallM(stallM), .dmem_req(dmem_req),
      .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .regwriteW(regwriteW), .RdW(RdW), .resultW(resultW),
`ifdef MEM_WB_PERF_EN
      .stall_cnt(stall_cnt),
`endif
      .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: an in-flight memory op is either waiting for acceptance or accepted
   // and waiting for its response; W reflects whichever instruction retired.
   logic        m_granted;
   logic        e_we, e_mis;
   logic [4:0]  e_rd;
   logic [31:0] e_res, e_cnt;

   function automatic logic aligned_mem();
      return validM && (resultsrcM || memwriteM) && (aluresultM % 4 == 0);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_granted <= 0; e_we <= 0; e_rd <= 0; e_res <= 0; e_mis <= 0; e_cnt <= 0;
      end else begin
         logic mem, amem, retire_mem;
         mem        = validM && (resultsrcM || memwriteM);
         amem       = aligned_mem();
         retire_mem = amem && m_granted && dmem_rvalid;
         e_mis <= mem && !amem;
         if (amem && !retire_mem && e_cnt != 32'hFFFF_FFFF) e_cnt <= e_cnt + 1;
         if (retire_mem) m_granted <= 0;
         else if (amem && dmem_gnt) m_granted <= 1;
         if (!validM || (mem && !retire_mem) || (retire_mem && memwriteM)) begin
            e_we <= 0;
         end else begin
            e_we  <= regwriteM && (RdM != 0);
            e_rd  <= RdM;
            e_res <= retire_mem ? dmem_rdata : aluresultM;
         end
      end
   end

   int stall_cyc, req_cyc, mis_cyc, we_cyc;

   always @(negedge clk) begin
      if (rst) begin
         chk("req_in_reset", {31'd0, dmem_req}, 32'd0);
      end else begin
         logic amem;
         amem = aligned_mem();
         chk("stallM", {31'd0, stallM}, {31'd0, amem && !(m_granted && dmem_rvalid)});
         chk("dmem_req", {31'd0, dmem_req}, {31'd0, amem && !m_granted});
         if (amem && !m_granted) begin
            chk("dmem_we", {31'd0, dmem_we}, {31'd0, memwriteM});
            chk("dmem_addr", dmem_addr, aluresultM);
            chk("dmem_wdata", dmem_wdata, Rd2M);
         end
         chk("regwriteW", {31'd0, regwriteW}, {31'd0, e_we});
         chk("RdW", {27'd0, RdW}, {27'd0, e_rd});
         chk("resultW", resultW, e_res);
         chk("misalign_err", {31'd0, misalign_err}, {31'd0, e_mis});
`ifdef MEM_WB_PERF_EN
         chk("stall_cnt", stall_cnt, e_cnt);
`endif
         stall_cyc += int'(stallM);
         req_cyc   += int'(dmem_req);
         mis_cyc   += int'(misalign_err);
         we_cyc    += int'(regwriteW);
      end
   end

   task automatic clr();
      stall_cyc = 0; req_cyc = 0; mis_cyc = 0; we_cyc = 0;
   endtask

   // Memory response for the cycle ending at the next edge.
   task automatic step(input logic g, input logic rv, input logic [31:0] rd);
      dmem_gnt = g; dmem_rvalid = rv; dmem_rdata = rd;
      @(posedge clk); #1;
   endtask

   task automatic setm(input logic v, input logic rw, input logic rs, input logic mw,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
      validM = v; regwriteM = rw; resultsrcM = rs; memwriteM = mw;
      aluresultM = a; Rd2M = d; RdM = r;
   endtask

   initial begin
      rst = 1'b1;
      setm(0, 0, 0, 0, 0, 0, 0);
      dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
      clr();
      #1;
      chk("rst_regwriteW", {31'd0, regwriteW}, 32'd0);
      chk("rst_resultW", resultW, 32'd0);
      chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // 1: ALU op
      clr();
      setm(1, 1, 0, 0, 32'h1234, 32'h0, 5'd5);
      step(0, 0, 0);
      setm(0, 0, 0, 0, 0, 0, 0);
      chk("t1_we", {31'd0, regwriteW}, 32'd1);
      chk("t1_rd", {27'd0, RdW}, 32'd5);
      chk("t1_res", resultW, 32'h1234);
      chk("t1_stall", stall_cyc, 0);
      step(0, 0, 0);
      chk("t1_bubble_hold", resultW, 32'h1234);

      // 2: load, immediate gnt, rvalid next cycle
      clr();
      setm(1, 1, 1, 0, 32'h40, 32'h0, 5'd7);
      step(1, 0, 0);
      step(0, 1, 32'hDEADBEEF);
      setm(0, 0, 0, 0, 0, 0, 0);
      chk("t2_we", {31'd0, regwriteW}, 32'd1);
      chk("t2_rd", {27'd0, RdW}, 32'd7);
      chk("t2_res", resultW, 32'hDEADBEEF);
      chk("t2_stall", stall_cyc, 1);
      step(0, 0, 0);

      // 3: store, gnt after 3 cycles, stray rvalid in REQ ignored
      clr();
      setm(1, 1, 0, 1, 32'h80, 32'hA5A5A5A5, 5'd9);
      step(0, 0, 0);
      step(0, 1, 32'h1111_1111);
      step(0, 0, 0);
      step(1, 0, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      setm(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0);
      chk("t3_req", req_cyc, 4);
      chk("t3_stall", stall_cyc, 5);
      chk("t3_we", we_cyc, 0);

      // 4: load to x0
      clr();
      setm(1, 1, 1, 0, 32'h44, 32'h0, 5'd0);
      step(1, 0, 0);
      step(0, 1, 32'hFFFFFFFF);
      setm(0, 0, 0, 0, 0, 0, 0);
      chk("t4_we", {31'd0, regwriteW}, 32'd0);
      step(0, 0, 0);

      // 5: misaligned load
      clr();
      setm(1, 1, 1, 0, 32'h41, 32'h0, 5'd3);
      step(0, 0, 0);
      setm(0, 0, 0, 0, 0, 0, 0);
      chk("t5_mis", {31'd0, misalign_err}, 32'd1);
      chk("t5_we", {31'd0, regwriteW}, 32'd0);
      step(0, 0, 0);
      chk("t5_mis_pulse", mis_cyc, 1);
      chk("t5_req", req_cyc, 0);
      chk("t5_stall", stall_cyc, 0);

      // 6: reset while waiting for response, late rvalid ignored
      clr();
      setm(1, 1, 1, 0, 32'h48, 32'h0, 5'd4);
      step(1, 0, 0);
      rst = 1'b1;
      #1;
      chk("t6_req_rst", {31'd0, dmem_req}, 32'd0);
      setm(0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
`ifdef MEM_WB_PERF_EN
      chk("t6_cnt", stall_cnt, 32'd0);
`endif
      step(0, 1, 32'h12345678);
      chk("t6_we", {31'd0, regwriteW}, 32'd0);
      chk("t6_res", resultW, 32'd0);
      setm(1, 1, 0, 0, 32'h55, 32'h0, 5'd9);
      step(0, 0, 0);
      setm(0, 0, 0, 0, 0, 0, 0);
      chk("t6_recover_rd", {27'd0, RdW}, 32'd9);
      chk("t6_recover_res", resultW, 32'h55);
      step(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
